// File: rtl/arbiter4_rr_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface arbiter4_rr_if;
    logic [3:0] request_i;
    logic [3:0] done_i;
    logic [3:0] grant_o;
    logic [1:0] select_o;
    logic       valid_o;

    modport master (
        output request_i,
        output done_i,
        input  grant_o,
        input  select_o,
        input  valid_o
    );

    modport slave (
        input  request_i,
        input  done_i,
        output grant_o,
        output select_o,
        output valid_o
    );
endinterface

// File: rtl/arbiter4_rr.sv
// Four-way round-robin arbiter with a per-grant hold limit; drives the 4:1 mux select.
// All outputs are flops, and grant/select always update on the same edge.
module arbiter4_rr #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic          clock_i,
    input  logic          reset_i,
    arbiter4_rr_if.slave  bus
);

    localparam int unsigned HCW = $clog2(HOLD_MAX + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e         state_q;
    logic [1:0]     ptr_q;
    logic [HCW-1:0] hcnt_q;
    logic [3:0]     grant_q;
    logic [1:0]     select_q;
    logic           valid_q;

    logic           win_found;
    logic [1:0]     win_idx;
    logic [1:0]     scan_idx;
    logic           release_now;
    logic [HCW-1:0] hcnt_d;

    // Rotating scan from ptr_q; the descending loop lets the nearest requester win.
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        scan_idx  = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            scan_idx = ptr_q + 2'(i);
            if (bus.request_i[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Only the current owner's done bit counts; other bits are ignored.
    always_comb begin
        release_now = bus.done_i[select_q]
                    | ~bus.request_i[select_q]
                    | (hcnt_q == HCW'(HOLD_MAX));
        hcnt_d      = hcnt_q + HCW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 2'd0;
            hcnt_q   <= '0;
            grant_q  <= 4'b0000;
            select_q <= 2'd0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        state_q  <= ST_GRANT;
                        grant_q  <= 4'b0001 << win_idx;
                        select_q <= win_idx;
                        valid_q  <= 1'b1;
                        ptr_q    <= win_idx + 2'd1;
                        hcnt_q   <= HCW'(1);
                    end
                end
                ST_GRANT: begin
                    if (!release_now) begin
                        hcnt_q <= hcnt_d;
                    end else if (win_found) begin
                        // Direct handover: ptr_q already points past the releasing owner.
                        grant_q  <= 4'b0001 << win_idx;
                        select_q <= win_idx;
                        valid_q  <= 1'b1;
                        ptr_q    <= win_idx + 2'd1;
                        hcnt_q   <= HCW'(1);
                    end else begin
                        state_q <= ST_IDLE;
                        grant_q <= 4'b0000;
                        valid_q <= 1'b0;
                        hcnt_q  <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 4'b0000;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant_o  = grant_q;
    assign bus.select_o = select_q;
    assign bus.valid_o  = valid_q;

endmodule

// File: tb/tb_arbiter4_rr.sv
// Directed bench for arbiter4_rr with HOLD_MAX = 4; expectations are queued when
// stimulus is driven and popped for comparison one clock edge later.
module tb_arbiter4_rr;

    typedef struct {
        string      tag;
        logic       valid;
        logic [1:0] sel;
        logic [3:0] grant;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb_q[$];

    arbiter4_rr_if bus ();

    arbiter4_rr #(.HOLD_MAX(4)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the outcome expected after the next rising edge, then score it.
    task automatic step(input string tag, input logic r, input logic [3:0] req,
                        input logic [3:0] done, input logic exp_valid, input logic [1:0] exp_sel);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst           = r;
        bus.request_i = req;
        bus.done_i    = done;
        e.tag   = tag;
        e.valid = exp_valid;
        e.sel   = exp_sel;
        e.grant = exp_valid ? (4'b0001 << exp_sel) : 4'b0000;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check({tag, "/queue"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            check({got.tag, "/valid"}, 32'(bus.valid_o),  32'(got.valid));
            check({got.tag, "/select"}, 32'(bus.select_o), 32'(got.sel));
            check({got.tag, "/grant"}, 32'(bus.grant_o),  32'(got.grant));
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.request_i = 4'b0000;
        bus.done_i    = 4'b0000;

        // Reset held two cycles with everyone requesting.
        step("rst0", 1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0);
        step("rst1", 1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0);

        // Full contention: first grant to 0, then 4-cycle slots rotating with no bubble.
        for (int i = 0; i < 17; i++) begin
            step($sformatf("contend%0d", i), 1'b0, 4'b1111, 4'b0000, 1'b1, 2'((i / 4) % 4));
        end

        // Single requester, released by done together with its request dropping.
        step("single_rst", 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0);
        step("single_e0", 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd0);
        step("single_e1", 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd0);
        step("single_e2", 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd0);
        step("single_e3", 1'b0, 4'b0000, 4'b0001, 1'b0, 2'd0);
        step("single_idle", 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Sparse requests: 1 first, done hands straight to 3, then back to 1.
        step("sparse_rst", 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0);
        step("sparse_g1", 1'b0, 4'b1010, 4'b0000, 1'b1, 2'd1);
        step("sparse_h1", 1'b0, 4'b1010, 4'b0000, 1'b1, 2'd1);
        step("sparse_d1", 1'b0, 4'b1010, 4'b0010, 1'b1, 2'd3);
        step("sparse_h3", 1'b0, 4'b1010, 4'b0000, 1'b1, 2'd3);
        step("sparse_d3", 1'b0, 4'b1010, 4'b1000, 1'b1, 2'd1);
        // Done in the first grant cycle gives a one-cycle grant.
        step("sparse_first", 1'b0, 4'b1010, 4'b0010, 1'b1, 2'd3);

        // Owner 3 drops its request, 2 takes over; foreign done[0] ignored; 2 drops, 0 wins.
        step("drop_g2", 1'b0, 4'b0100, 4'b0000, 1'b1, 2'd2);
        step("foreign_done", 1'b0, 4'b0101, 4'b0001, 1'b1, 2'd2);
        step("drop_to0", 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd0);

        // Reset during the second cycle of a grant to index 3.
        step("mid_g3", 1'b0, 4'b1000, 4'b0000, 1'b1, 2'd3);
        step("mid_h3", 1'b0, 4'b1000, 4'b0000, 1'b1, 2'd3);
        step("mid_rst", 1'b1, 4'b1000, 4'b0000, 1'b0, 2'd0);
        step("post_rst", 1'b0, 4'b1001, 4'b0000, 1'b1, 2'd0);

        // Hold limit forces 0 off after 4 cycles, then select holds its value while idle.
        step("hold_c2", 1'b0, 4'b1001, 4'b0000, 1'b1, 2'd0);
        step("hold_c3", 1'b0, 4'b1001, 4'b0000, 1'b1, 2'd0);
        step("hold_c4", 1'b0, 4'b1001, 4'b0000, 1'b1, 2'd0);
        step("hold_to3", 1'b0, 4'b1001, 4'b0000, 1'b1, 2'd3);
        step("idle_hold0", 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd3);
        step("idle_hold1", 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd3);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbiter4_rr.md
# arbiter4_rr

Four-way round-robin arbiter that drives the select input of the 4:1 datapath multiplexer (`mux4to1`). It sits directly upstream of the mux: four requesters contend for one shared path, and the arbiter grants one at a time. It outputs a one-hot grant back to the requesters and a 2-bit binary select to the mux. Fairness comes from a rotating priority pointer, and a hold limit bounds how long any one requester can keep the path.

## Interface
Parameters:
- `HOLD_MAX`, 16, maximum consecutive cycles a single grant may last; legal range ≥ 1.

Ports:
- `clock_i`  in  1  system clock; all state changes on rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `request_i`  in  4  per-requester request, level-sensitive.
- `done_i`  in  4  per-requester release strobe; only the bit of the current owner is honoured.
- `grant_o`  out  4  one-hot grant, registered; all-zero when idle.
- `select_o`  out  2  binary index of current owner, registered; drives mux `select_i`.
- `valid_o`  out  1  high while a grant is active (`valid_o == |grant_o`).

## Operation
- State machine: IDLE and GRANT.
- Internal state:
  - Priority pointer `ptr` (2 bits).
  - Hold counter `hcnt`, width clog2(HOLD_MAX+1).
- Arbitration pick:
  - Scan indices `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
  - The first index with its request bit set wins.
- IDLE:
  - If `request_i != 0`, pick a winner and go to GRANT.
  - Registered outputs: `grant_o` = one-hot(winner), `select_o` = winner, `valid_o` = 1.
  - Also set `ptr` = winner+1 (mod 4) and `hcnt` = 1.
  - Else stay in IDLE.
- GRANT:
  - `hcnt` increments each cycle the grant is held.
  - Release condition, evaluated at each edge while in GRANT:
    - `done_i[select_o]` is high, or
    - `request_i[select_o]` is low, or
    - `hcnt == HOLD_MAX`.
  - On release, handover is direct with no bubble. The pick is re-run using the updated `ptr`, so the releasing owner has lowest priority.
    - Any request present (including the releasing owner's own): grant the winner as in IDLE and reset `hcnt` to 1.
    - No request present: go to IDLE with `grant_o` = 0 and `valid_o` = 0.
  - `done_i` bits of non-owners are ignored.
- `select_o` holds its last value while IDLE. It is never X and never changes without a new grant.
- Simultaneous release and new request: the new request is considered in the same pick, so no cycle is lost.
- HOLD_MAX = 1: every grant lasts exactly one cycle, and contending requesters alternate every cycle.
- Reset asserted at any time, including mid-grant, returns the block to its reset values on the next edge:
  - State IDLE.
  - `grant_o` = 0, `select_o` = 0, `valid_o` = 0.
  - `ptr` = 0, `hcnt` = 0.

## Timing
- All outputs come directly from flops; there is no combinational path from inputs to outputs.
- Request-to-grant latency: 1 cycle. A request sampled at edge N produces `grant_o` valid after edge N.
- Release latency: 1 cycle. `done_i` sampled at edge N changes or drops the grant after edge N.
- A grant whose owner asserts `done_i` in its first grant cycle lasts exactly 1 cycle.
- Maximum grant length: HOLD_MAX cycles.
- Worst-case wait for a continuously requesting requester: 3·HOLD_MAX cycles.
- `select_o` and `grant_o` always change on the same edge, so the mux output is stable for the whole grant.

## Test plan
All scenarios use HOLD_MAX = 4.
- Reset: hold `reset_i` for 2 cycles with `request_i` = 4'b1111 → `grant_o` = 0, `select_o` = 0, `valid_o` = 0 throughout. After reset is released, the first grant goes to index 0 one cycle later.
- Single requester: `request_i` = 4'b0001 set before edge 0; `done_i[0]` pulsed and sampled at edge 3 → `grant_o` = 0001, `select_o` = 00 after edges 0, 1, 2; after edge 3, `grant_o` = 0 and `valid_o` = 0.
- Full contention: `request_i` = 4'b1111 held, `done_i` = 0 → `select_o` sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…, with no idle cycle between grants.
- Sparse requests after reset: `request_i` = 4'b1010 → index 1 is granted first. When it releases via `done_i[1]`, index 3 is granted on the next cycle with no bubble.
- Request drop and foreign done: owner 2 deasserts `request_i[2]` on its 2nd grant cycle → grant moves on the next edge. `done_i[0]` pulsed while 2 owns the path → no effect.
- Reset mid-grant: assert `reset_i` on cycle 2 of a grant to index 3 → on the next edge, `grant_o` = 0, `select_o` = 0, `valid_o` = 0. After reset, `ptr` = 0 and index 0 wins if requesting.
